// File: rtl/cic_comp_fir.sv
// Serial-MAC 11-tap inverse-sinc compensation FIR placed after the CIC decimator.
// Optional build macro CIC_COMP_SAT_EN: clamp the output instead of two's-complement wrap.
module cic_comp_fir #(
   parameter int DIN_W     = 17,
   parameter int DOUT_W    = 17,
   parameter int COEF_W    = 12,
   parameter int NTAP      = 11,
   parameter int COEF_FRAC = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DIN_W-1:0]  din,
   input  logic                     din_vld,
   output logic signed [DOUT_W-1:0] dout,
   output logic                     dout_vld,
   output logic                     busy,
   output logic                     ovr
);

   localparam int PROD_W = DIN_W + COEF_W;
   localparam int ACC_W  = PROD_W + 4;
   localparam int KW     = $clog2(NTAP);

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_FRAC - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX =
      {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN =
      {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, RND} state_t;

   state_t                    state, state_nxt;
   logic signed [DIN_W-1:0]   x [NTAP];
   logic signed [ACC_W-1:0]   acc;
   logic [KW-1:0]             k;
   logic signed [DIN_W-1:0]   x_sel;
   logic signed [COEF_W-1:0]  h_sel;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   y_full;
   logic signed [DOUT_W-1:0]  y_out;

   // Symmetric inverse-sinc taps, sum 1024 so DC gain is exactly 1.
   function automatic logic signed [COEF_W-1:0] coef(input logic [KW-1:0] idx);
      case (idx)
         4'd0, 4'd10: coef = -12'sd4;
         4'd1, 4'd9:  coef = 12'sd10;
         4'd2, 4'd8:  coef = -12'sd24;
         4'd3, 4'd7:  coef = 12'sd48;
         4'd4, 4'd6:  coef = -12'sd96;
         4'd5:        coef = 12'sd1156;
         default:     coef = '0;
      endcase
   endfunction

   always_comb begin
      x_sel = '0;
      for (int i = 0; i < NTAP; i++)
         if (k == KW'(i)) x_sel = x[i];
   end

   assign h_sel  = coef(k);
   assign prod   = PROD_W'(x_sel) * PROD_W'(h_sel);
   assign y_full = (acc + RND_HALF) >>> COEF_FRAC;

`ifdef CIC_COMP_SAT_EN
   always_comb begin
      y_out = y_full[DOUT_W-1:0];
      if (y_full > Y_MAX)      y_out = Y_MAX[DOUT_W-1:0];
      else if (y_full < Y_MIN) y_out = Y_MIN[DOUT_W-1:0];
   end
`else
   always_comb begin
      y_out = y_full[DOUT_W-1:0];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (din_vld) state_nxt = MAC;
         MAC:     if (k == KW'(NTAP - 1)) state_nxt = RND;
         RND:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAP; i++) x[i] <= '0;
         acc      <= '0;
         k        <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         ovr      <= 1'b0;
      end else begin
         dout_vld <= 1'b0;
         case (state)
            IDLE: if (din_vld) begin
               x[0] <= din;
               for (int i = 1; i < NTAP; i++) x[i] <= x[i-1];
               acc <= '0;
               k   <= '0;
            end
            MAC: begin
               acc <= acc + ACC_W'(prod);
               k   <= k + KW'(1);
            end
            RND: begin
               dout     <= y_out;
               dout_vld <= 1'b1;
            end
            default: ;
         endcase
         // Any strobe outside IDLE is lost; the delay line is left alone.
         if (din_vld && state != IDLE) ovr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: vector table for impulse/DC/overflow, hand sequences
// for reset, overrun, RND-cycle strobe, minimum spacing and reset mid-pass.
module tb_cic_comp_fir;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [16:0] din;
   logic               din_vld;
   logic signed [16:0] dout;
   logic               dout_vld;
   logic               busy;
   logic               ovr;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int din;
      int exp;
      bit chk;
   } vec_t;

   vec_t vecs [37];
   int   h_tab [11] = '{-4, 10, -24, 48, -96, 1156, -96, 48, -24, 10, -4};

   cic_comp_fir dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_vld  (din_vld),
      .dout     (dout),
      .dout_vld (dout_vld),
      .busy     (busy),
      .ovr      (ovr)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe one sample; returns 1 ns after the edge that samples it.
   task automatic strobe(input int d);
      din     = d[16:0];
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
   endtask

   task automatic wait_vld(input int max_edges, output int lat, output int got);
      lat = -1;
      got = 0;
      for (int i = 1; i <= max_edges; i++) begin
         tick();
         if (dout_vld) begin
            lat = i;
            got = dout;
            break;
         end
      end
   endtask

   // One sample with spacing 20: latency, value and pulse width checked.
   task automatic run_vec(input vec_t v, input string nm);
      int lat, got;
      strobe(v.din);
      check({nm, "_busy"}, int'(busy), 1);
      wait_vld(19, lat, got);
      check({nm, "_lat"}, lat, 12);
      if (v.chk) check({nm, "_dout"}, got, v.exp);
      if (lat > 0) begin
         tick();
         check({nm, "_pulse"}, int'(dout_vld), 0);
         repeat (18 - lat) tick();
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int lat, got, seen;

      for (int i = 0; i < 11; i++) vecs[i] = '{(i == 0) ? 1024 : 0, h_tab[i], 1'b1};
      vecs[11] = '{0, 0, 1'b1};
      for (int i = 12; i < 24; i++) vecs[i] = '{1000, 1000, (i >= 22)};
      for (int j = 0; j < 13; j++) begin
         vecs[24+j].din = (j % 2 == 0) ? 60000 : -60000;
`ifdef CIC_COMP_SAT_EN
         vecs[24+j].exp = (j % 2 == 0) ? -65536 : 65535;
`else
         vecs[24+j].exp = (j % 2 == 0) ? 42010 : -42009;
`endif
         vecs[24+j].chk = (j >= 11);
      end

      // Reset state while held and after release.
      rst = 1'b1; din = '0; din_vld = 1'b0;
      repeat (3) tick();
      check("rst_dout", int'(dout), 0);
      check("rst_vld", int'(dout_vld), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovr", int'(ovr), 0);
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_dout", int'(dout), 0);
      check("post_rst_vld", int'(dout_vld), 0);

      for (int i = 0; i < 37; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      check("no_ovr_after_table", int'(ovr), 0);

      // Overrun: second strobe 5 clocks after the first is dropped.
      pulse_rst();
      strobe(1024);
      repeat (4) tick();
      strobe(5000);
      check("ovr_set", int'(ovr), 1);
      wait_vld(19, lat, got);
      check("ovr_first_lat", lat, 7);
      check("ovr_first_dout", got, -4);
      repeat (10) tick();
      run_vec('{0, 10, 1'b1}, "ovr_next");
      check("ovr_sticky", int'(ovr), 1);

      // Strobe during RND is dropped.
      pulse_rst();
      strobe(1024);
      repeat (11) tick();
      strobe(777);
      check("rnd_vld", int'(dout_vld), 1);
      check("rnd_dout", int'(dout), -4);
      check("rnd_ovr", int'(ovr), 1);
      repeat (10) tick();
      run_vec('{0, 10, 1'b1}, "rnd_next");

      // Minimum spacing of 13 clocks is accepted.
      pulse_rst();
      strobe(1024);
      repeat (11) tick();
      check("sp13_busy_rnd", int'(busy), 1);
      tick();
      check("sp13_vld", int'(dout_vld), 1);
      check("sp13_dout", int'(dout), -4);
      strobe(0);
      wait_vld(19, lat, got);
      check("sp13_lat", lat, 12);
      check("sp13_dout2", got, 10);
      check("sp13_ovr", int'(ovr), 0);
      repeat (8) tick();

      // Reset mid-pass aborts the result.
      pulse_rst();
      strobe(1024);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("abort_busy", int'(busy), 0);
      seen = 0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dout_vld) seen++;
      end
      check("abort_no_vld", seen, 0);
      check("abort_busy_after", int'(busy), 0);
      check("abort_ovr", int'(ovr), 0);
      check("abort_dout", int'(dout), 0);
      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("rerun%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
